sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 181 ++++++++++++++++++
 tb/tb_sram_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Behavioural responder for an asynchronous-style 16-bit SRAM bus with byte lanes.
// Models read/write latency, tracks protocol violations and counts completed accesses.
module sram_responder #(
  parameter int ADDR_BITS = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_OE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    READ_DRIVE = 3'd2,
    WRITE_WAIT = 3'd3,
    WRITE_HOLD = 3'd4
  } state_e;

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] RD_LAT = 4'(READ_LAT);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LAT);

  logic [15:0] mem [DEPTH];

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   a_q, a_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [15:0]            rd_cnt_q, rd_cnt_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;
  logic                   commit_s;
  logic                   drive_s;
  logic [ADDR_BITS-1:0]   addr_s;
  logic                   addr_chg_s;

  assign addr_s     = SRAM_ADDR[ADDR_BITS-1:0];
  assign addr_chg_s = (addr_s != a_q);

  // next-state, counters and commit strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
          a_d     = addr_s;
          cnt_d   = 4'd1;
          state_d = WRITE_WAIT;
        end else if (!SRAM_CE_N && !SRAM_OE_N) begin
          a_d     = addr_s;
          cnt_d   = 4'd1;
          state_d = READ_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      READ_WAIT: begin
        if (SRAM_CE_N || SRAM_OE_N || !SRAM_WE_N) begin
          state_d = IDLE;
        end else if (addr_chg_s) begin
          a_d   = addr_s;
          cnt_d = 4'd1;
        end else if (cnt_q == RD_LAT) begin
          rdata_d  = mem[a_q];
          rd_cnt_d = rd_cnt_q + 16'd1;
          state_d  = READ_DRIVE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      READ_DRIVE: begin
        // a write request takes precedence over the OE_N de-assertion that usually accompanies it
        if (SRAM_CE_N) begin
          state_d = IDLE;
        end else if (!SRAM_WE_N) begin
          a_d     = addr_s;
          cnt_d   = 4'd1;
          state_d = WRITE_WAIT;
        end else if (SRAM_OE_N) begin
          state_d = IDLE;
        end else if (addr_chg_s) begin
          a_d     = addr_s;
          cnt_d   = 4'd1;
          state_d = READ_WAIT;
        end else begin
          state_d = READ_DRIVE;
        end
      end
      WRITE_WAIT: begin
        // reaching the latency commits even if WE_N rises on that same edge
        if (!SRAM_WE_N && addr_chg_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == WR_LAT) begin
          commit_s = 1'b1;
          wr_cnt_d = wr_cnt_q + 16'd1;
          state_d  = WRITE_HOLD;
        end else if (SRAM_WE_N || SRAM_CE_N) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE_HOLD: begin
        if (SRAM_WE_N || SRAM_CE_N) begin
          state_d = IDLE;
        end else if (addr_chg_s) begin
          err_d = 1'b1;
        end else begin
          state_d = WRITE_HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // control state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      a_q      <= '0;
      rdata_q  <= 16'd0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // array write, per enabled byte lane; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_s && !rst) begin
      if (!SRAM_UB_N) begin
        mem[a_q][15:8] <= SRAM_DQ[15:8];
      end
      if (!SRAM_LB_N) begin
        mem[a_q][7:0] <= SRAM_DQ[7:0];
      end
    end
  end

  // bus released combinationally as soon as the master drops any read control
  assign drive_s = (state_q == READ_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[15:8] = (drive_s && !SRAM_UB_N) ? rdata_q[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive_s && !SRAM_LB_N) ? rdata_q[7:0]  : 8'hzz;

  assign err    = err_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus queues expected values stamped with a
// cycle number, a negedge monitor pops and compares them. Released bus lines read as 1.
module tb_sram_responder;

  localparam int ADDR_BITS = 10;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 2;
  localparam logic [15:0] ZZ = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic [15:0] dq_drv;
  logic        dq_oe;
  wire  [15:0] sram_dq;
  logic        err;
  logic [15:0] rd_cnt, wr_cnt;

  assign sram_dq = dq_oe ? dq_drv : 16'hzzzz;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (sram_dq[i]);
    end
  endgenerate

  sram_responder #(
    .ADDR_BITS(ADDR_BITS),
    .READ_LAT (READ_LAT),
    .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_ADDR(addr),
    .SRAM_DQ  (sram_dq),
    .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n),
    .err      (err),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          q_cyc[$];
  int          q_sel[$];
  logic [15:0] q_val[$];
  string       q_name[$];

  logic [15:0] exp_rd  = 16'd0;
  logic [15:0] exp_wr  = 16'd0;
  logic        exp_err = 1'b0;

  task automatic expect_v(input string name, input int sel, input logic [15:0] val);
    q_cyc.push_back(cyc);
    q_sel.push_back(sel);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  task automatic expect_state(input string name);
    expect_v({name, " err"}, 1, {15'd0, exp_err});
    expect_v({name, " rd_cnt"}, 2, exp_rd);
    expect_v({name, " wr_cnt"}, 3, exp_wr);
  endtask

  // monitor: compare every queued expectation due in this cycle
  always @(negedge clk) begin : monitor
    logic [15:0] act;
    logic [15:0] expv;
    int          sel;
    string       name;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      void'(q_cyc.pop_front());
      sel  = q_sel.pop_front();
      expv = q_val.pop_front();
      name = q_name.pop_front();
      case (sel)
        0:       act = sram_dq;
        1:       act = {15'd0, err};
        2:       act = rd_cnt;
        default: act = wr_cnt;
      endcase
      n_checks++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_n  = 1'b1;
    we_n  = 1'b1;
    oe_n  = 1'b1;
    ub_n  = 1'b0;
    lb_n  = 1'b0;
    dq_oe = 1'b0;
  endtask

  // WE_N held low for n_low edges, data held one more edge, then bus released
  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input int n_low);
    addr   = a;
    dq_drv = d;
    dq_oe  = 1'b1;
    ub_n   = ub;
    lb_n   = lb;
    oe_n   = 1'b1;
    ce_n   = 1'b0;
    we_n   = 1'b0;
    repeat (n_low) tick();
    we_n = 1'b1;
    ce_n = 1'b1;
    tick();
    bus_idle();
    tick();
    if (n_low >= WRITE_LAT) exp_wr = exp_wr + 16'd1;
    else exp_err = 1'b1;
  endtask

  task automatic do_read(input logic [17:0] a, input logic ub, input logic lb,
                         input logic [15:0] exp_dq, input string name);
    addr  = a;
    ub_n  = ub;
    lb_n  = lb;
    dq_oe = 1'b0;
    we_n  = 1'b1;
    ce_n  = 1'b0;
    oe_n  = 1'b0;
    tick();
    tick();
    expect_v({name, " pre"}, 0, ZZ);
    tick();
    exp_rd = exp_rd + 16'd1;
    expect_v(name, 0, exp_dq);
    tick();
    oe_n = 1'b1;
    expect_v({name, " oe_off"}, 0, ZZ);
    tick();
    bus_idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    addr   = 18'd0;
    dq_drv = 16'd0;
    bus_idle();
    tick();
    tick();
    expect_state("reset");
    expect_v("reset dq", 0, ZZ);
    tick();
    rst = 1'b0;
    tick();

    do_write(18'd5, 16'hA5C3, 1'b0, 1'b0, 2);
    do_read(18'd5, 1'b0, 1'b0, 16'hA5C3, "basic read");
    expect_state("basic counts");
    tick();

    do_write(18'd9, 16'hFFFF, 1'b0, 1'b0, 2);
    do_write(18'd9, 16'h1234, 1'b1, 1'b0, 2);
    do_read(18'd9, 1'b0, 1'b0, 16'hFF34, "lane merge");
    do_read(18'd9, 1'b0, 1'b1, 16'hFFFF, "lb off read");
    do_read(18'd5, 1'b1, 1'b0, 16'hFFC3, "ub off read");
    do_read(18'd5, 1'b0, 1'b1, 16'hA5FF, "lb off read2");
    expect_state("lane counts");
    tick();

    do_write(18'h00405, 16'hBEEF, 1'b0, 1'b0, 2);
    do_read(18'd5, 1'b0, 1'b0, 16'hBEEF, "alias read");
    do_read(18'h3FC05, 1'b0, 1'b0, 16'hBEEF, "alias high read");

    do_write(18'd5, 16'h0000, 1'b1, 1'b1, 2);
    do_read(18'd5, 1'b0, 1'b0, 16'hBEEF, "null lane write");
    expect_state("null lane counts");
    tick();

    do_write(18'd5, 16'h1111, 1'b0, 1'b0, 1);
    expect_state("short write");
    do_read(18'd5, 1'b0, 1'b0, 16'hBEEF, "short no commit");
    expect_state("err sticky");
    tick();

    do_write(18'd7, 16'h1111, 1'b0, 1'b0, 2);
    addr   = 18'd7;
    dq_drv = 16'h2222;
    dq_oe  = 1'b1;
    oe_n   = 1'b1;
    ce_n   = 1'b0;
    we_n   = 1'b0;
    tick();
    dq_oe   = 1'b0;
    rst     = 1'b1;
    exp_err = 1'b0;
    exp_rd  = 16'd0;
    exp_wr  = 16'd0;
    expect_state("rst mid write");
    expect_v("rst mid write dq", 0, ZZ);
    tick();
    rst = 1'b0;
    bus_idle();
    tick();
    do_read(18'd7, 1'b0, 1'b0, 16'h1111, "rst no commit");
    expect_state("after rst counts");
    tick();

    force dut.wr_cnt_q = 16'hFFFF;
    tick();
    release dut.wr_cnt_q;
    exp_wr = 16'hFFFF;
    tick();
    do_write(18'd3, 16'h5555, 1'b0, 1'b0, 2);
    expect_state("wr_cnt wrap");
    tick();
    tick();

    n_checks++;
    if (q_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q_cyc.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
